rtc_time_editor: RTL and testbench

Button-driven time/date editor between the debouncers and the RTC bus controller. It snapshots the current BCD time, lets the user move a field cursor and step values with wrap-around, and on exit writes the six edited fields back through a request/acknowledge write port. The cursor and live edit buffer also go to the VGA stage for highlighting.

---
 rtl/rtc_time_editor_if.sv | 11 +
 rtl/rtc_time_editor.sv | 145 ++++++++++++++
 tb/tb_rtc_time_editor.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rtc_time_editor_if.sv
// Write port from the time editor to the RTC bus controller.
// The editor holds wr_addr/wr_data steady while wr_req is high.
interface rtc_time_editor_if;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
  modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/rtc_time_editor.sv
// Button-driven BCD time/date editor: snapshots rtc_time, steps fields with
// wrap-around under a cursor, then writes all six fields back sec..year.
module rtc_time_editor #(
  parameter logic [7:0] ADDR_SEC  = 8'h21,
  parameter logic [7:0] ADDR_MIN  = 8'h22,
  parameter logic [7:0] ADDR_HOUR = 8'h23,
  parameter logic [7:0] ADDR_DAY  = 8'h24,
  parameter logic [7:0] ADDR_MON  = 8'h25,
  parameter logic [7:0] ADDR_YEAR = 8'h26
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                edit_en,
  input  logic                up,
  input  logic                down,
  input  logic                left,
  input  logic                rig,
  input  logic [47:0]         rtc_time,
  rtc_time_editor_if.master   wr,
  output logic                edit_active,
  output logic [2:0]          cursor,
  output logic [47:0]         edit_time
);

  typedef enum logic [1:0] {IDLE, EDIT, COMMIT_REQ, COMMIT_GAP} state_t;

  state_t          state;
  logic [4:0]      lvl_q, rise_q;   // {edit_en, rig, left, down, up}
  logic            fall_q;
  logic [5:0][7:0] fld;
  logic [2:0]      field, nfield;
  logic            req;
  logic [7:0]      addr, data;

  assign edit_time  = fld;
  assign wr.wr_req  = req;
  assign wr.wr_addr = addr;
  assign wr.wr_data = data;
  assign nfield     = field + 3'd1;

  function automatic logic [7:0] addr_of(input logic [2:0] idx);
    case (idx)
      3'd0:    addr_of = ADDR_SEC;
      3'd1:    addr_of = ADDR_MIN;
      3'd2:    addr_of = ADDR_HOUR;
      3'd3:    addr_of = ADDR_DAY;
      3'd4:    addr_of = ADDR_MON;
      default: addr_of = ADDR_YEAR;
    endcase
  endfunction

  // Valid BCD orders like binary, so range checks compare the raw bytes.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic inc,
                                          input logic [2:0] idx);
    logic [7:0] lo, hi;
    logic       ok;
    case (idx)
      3'd0, 3'd1: begin lo = 8'h00; hi = 8'h59; end
      3'd2:       begin lo = 8'h00; hi = 8'h23; end
      3'd3:       begin lo = 8'h01; hi = 8'h31; end
      3'd4:       begin lo = 8'h01; hi = 8'h12; end
      default:    begin lo = 8'h00; hi = 8'h99; end
    endcase
    ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
    if (!ok)                bcd_step = inc ? lo : hi;
    else if (inc) begin
      if (v == hi)          bcd_step = lo;
      else if (v[3:0] == 4'd9) bcd_step = {v[7:4] + 4'd1, 4'd0};
      else                  bcd_step = v + 8'd1;
    end else begin
      if (v == lo)          bcd_step = hi;
      else if (v[3:0] == 4'd0) bcd_step = {v[7:4] - 4'd1, 4'd9};
      else                  bcd_step = v - 8'd1;
    end
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_q  <= '0;
      rise_q <= '0;
      fall_q <= 1'b0;
    end else begin
      lvl_q  <= {edit_en, rig, left, down, up};
      rise_q <= {edit_en, rig, left, down, up} & ~lvl_q;
      fall_q <= ~edit_en & lvl_q[4];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req         <= 1'b0;
      addr        <= 8'h00;
      data        <= 8'h00;
      edit_active <= 1'b0;
      cursor      <= 3'd0;
      field       <= 3'd0;
      fld         <= '0;
    end else begin
      case (state)
        IDLE: begin
          fld <= rtc_time;
          if (rise_q[4]) begin
            cursor      <= 3'd0;
            edit_active <= 1'b1;
            state       <= EDIT;
          end
        end
        EDIT: begin
          if (fall_q) begin
            field <= 3'd0;
            state <= COMMIT_REQ;
          end else if (rise_q[0]) fld[cursor] <= bcd_step(fld[cursor], 1'b1, cursor);
          else if (rise_q[1])     fld[cursor] <= bcd_step(fld[cursor], 1'b0, cursor);
          else if (rise_q[2])     cursor <= (cursor == 3'd0) ? 3'd5 : cursor - 3'd1;
          else if (rise_q[3])     cursor <= (cursor == 3'd5) ? 3'd0 : cursor + 3'd1;
        end
        COMMIT_REQ: begin
          if (!req) begin
            req  <= 1'b1;
            addr <= addr_of(field);
            data <= fld[field];
          end else if (wr.wr_ack) begin
            req   <= 1'b0;
            state <= COMMIT_GAP;
          end
        end
        default: begin
          // The gap cycle launches the next write directly to keep 2 cycles/write.
          if (field == 3'd5) begin
            edit_active <= 1'b0;
            state       <= IDLE;
          end else begin
            field <= nfield;
            req   <= 1'b1;
            addr  <= addr_of(nfield);
            data  <= fld[nfield];
            state <= COMMIT_REQ;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_time_editor.sv
// Randomized bench for rtc_time_editor against an integer-arithmetic field model.
module tb_rtc_time_editor;
  logic        clk = 1'b0;
  logic        reset, edit_en, up, down, left, rig;
  logic [47:0] rtc_time;
  logic        edit_active;
  logic [2:0]  cursor;
  logic [47:0] edit_time;

  rtc_time_editor_if wif();

  rtc_time_editor dut (
    .clk(clk), .reset(reset), .edit_en(edit_en), .up(up), .down(down),
    .left(left), .rig(rig), .rtc_time(rtc_time), .wr(wif),
    .edit_active(edit_active), .cursor(cursor), .edit_time(edit_time)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [7:0] m [6];
  int mcur;
  int lo [6] = '{0, 0, 0, 1, 1, 0};
  int hi [6] = '{59, 59, 23, 31, 12, 99};
  logic [7:0] addrs [6] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] tobcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  function automatic logic [47:0] mpack();
    return {m[5], m[4], m[3], m[2], m[1], m[0]};
  endfunction

  function automatic logic [7:0] mstep(input logic [7:0] b, input bit inc, input int i);
    int n;
    n = int'(b[7:4]) * 10 + int'(b[3:0]);
    if (b[7:4] > 9 || b[3:0] > 9 || n < lo[i] || n > hi[i]) n = inc ? lo[i] : hi[i];
    else if (inc) n = (n == hi[i]) ? lo[i] : n + 1;
    else          n = (n == lo[i]) ? hi[i] : n - 1;
    return tobcd(n);
  endfunction

  task automatic enter(input logic [47:0] snap);
    rtc_time = snap;
    edit_en  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 6; i++) m[i] = snap[i*8 +: 8];
    mcur = 0;
    check("enter_active", 64'(edit_active), 64'd1);
    check("enter_cursor", 64'(cursor), 64'd0);
    check("enter_time", 64'(edit_time), 64'(mpack()));
    rtc_time = {$urandom, $urandom_range(65535, 0)};
  endtask

  // mask bits: 0 up, 1 down, 2 left, 3 rig
  task automatic press(input string tag, input int mask);
    {rig, left, down, up} = 4'(mask);
    @(negedge clk);
    {rig, left, down, up} = 4'b0;
    @(negedge clk);
    if (mask[0])      m[mcur] = mstep(m[mcur], 1'b1, mcur);
    else if (mask[1]) m[mcur] = mstep(m[mcur], 1'b0, mcur);
    else if (mask[2]) mcur = (mcur + 5) % 6;
    else if (mask[3]) mcur = (mcur + 1) % 6;
    check({tag, "_time"}, 64'(edit_time), 64'(mpack()));
    check({tag, "_cursor"}, 64'(cursor), 64'(mcur));
  endtask

  // delay 0: wr_ack held high throughout. abort_at >= 0: reset during that write.
  task automatic commit(input int delay, input int abort_at, input int btn_mask);
    int seen;
    if (delay == 0) wif.wr_ack = 1'b1;
    edit_en = 1'b0;
    {rig, left, down, up} = 4'(btn_mask);
    @(negedge clk);
    {rig, left, down, up} = 4'b0;
    for (int w = 0; w < 6; w++) begin
      seen = 0;
      for (int t = 0; t < 20 && !wif.wr_req; t++) @(negedge clk);
      check("req_seen", 64'(wif.wr_req), 64'd1);
      if (!wif.wr_req) break;
      check("wr_addr", 64'(wif.wr_addr), 64'(addrs[w]));
      check("wr_data", 64'(wif.wr_data), 64'(m[w]));
      if (w == abort_at) begin
        reset = 1'b1;
        wif.wr_ack = 1'b1;
        @(negedge clk);
        check("abort_req", 64'(wif.wr_req), 64'd0);
        check("abort_active", 64'(edit_active), 64'd0);
        reset = 1'b0;
        for (int t = 0; t < 20; t++) begin
          @(negedge clk);
          if (wif.wr_req) seen++;
        end
        check("abort_no_req", 64'(seen), 64'd0);
        wif.wr_ack = 1'b0;
        return;
      end
      if (delay > 0) begin
        for (int t = 1; t < delay; t++) begin
          @(negedge clk);
          check("req_hold", 64'({wif.wr_req, wif.wr_addr, wif.wr_data}),
                64'({1'b1, addrs[w], m[w]}));
        end
        wif.wr_ack = 1'b1;
      end
      @(negedge clk);
      check("req_drop", 64'(wif.wr_req), 64'd0);
      if (delay > 0) wif.wr_ack = 1'b0;
      @(negedge clk);
      if (w < 5) check("gap_one", 64'(wif.wr_req), 64'd1);
      else begin
        check("end_req", 64'(wif.wr_req), 64'd0);
        check("end_active", 64'(edit_active), 64'd0);
      end
    end
    wif.wr_ack = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [47:0] rand_snap();
    logic [47:0] s;
    for (int i = 0; i < 6; i++)
      s[i*8 +: 8] = ($urandom_range(3, 0) == 0) ? 8'($urandom) : tobcd($urandom_range(99, 0));
    return s;
  endfunction

  initial begin
    reset = 1'b1; edit_en = 1'b0; {rig, left, down, up} = 4'b0;
    wif.wr_ack = 1'b0;
    rtc_time = 48'h16_09_21_23_59_58;
    repeat (3) @(negedge clk);
    check("rst_req", 64'(wif.wr_req), 64'd0);
    check("rst_addr", 64'(wif.wr_addr), 64'd0);
    check("rst_data", 64'(wif.wr_data), 64'd0);
    check("rst_active", 64'(edit_active), 64'd0);
    check("rst_cursor", 64'(cursor), 64'd0);
    check("rst_time", 64'(edit_time), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_follow", 64'(edit_time), 64'h16_09_21_23_59_58);
    rtc_time = 48'h16_09_21_23_59_57;
    @(negedge clk);
    check("idle_follow2", 64'(edit_time), 64'h16_09_21_23_59_57);

    // Session 1: sec/hour wrap
    enter(48'h16_09_21_23_59_58);
    press("sec_up59", 1);
    press("sec_up00", 1);
    check("min_kept", 64'(edit_time[15:8]), 64'h59);
    press("rig1", 8);
    press("rig2", 8);
    press("hour_up", 1);
    check("hour_00", 64'(edit_time[23:16]), 64'h00);
    commit(0, -1, 0);

    // Session 2: cursor wrap, priority, day/mon boundaries
    enter(48'h16_1F_01_00_00_00);
    press("left_wrap", 4);
    check("cursor5", 64'(cursor), 64'd5);
    press("rig_wrap", 8);
    press("up_rig", 9);
    press("rig_a", 8); press("rig_b", 8); press("rig_c", 8);
    press("day_down", 2);
    check("day_31", 64'(edit_time[31:24]), 64'h31);
    press("rig_d", 8);
    press("mon_inv_up", 1);
    check("mon_01", 64'(edit_time[39:32]), 64'h01);
    press("all4", 15);
    commit(3, -1, 0);

    // Session 3: invalid mon down, falling edge beats a button, reset mid-commit
    enter(48'h99_A0_15_12_30_45);
    press("left_c", 4);
    press("left_d", 4);
    press("mon_inv_dn", 2);
    check("mon_12", 64'(edit_time[39:32]), 64'h12);
    commit(3, 2, 1);

    // Random sessions
    for (int s = 0; s < 4; s++) begin
      enter(rand_snap());
      for (int p = 0; p < 30; p++) press("rnd", int'($urandom_range(15, 1)));
      commit(int'($urandom_range(4, 0)), -1, int'($urandom_range(15, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
